// File: rtl/kamus_pkg.sv
// Shared types for the kamus CSR unit: CSR addresses, op codes,
// FSM states and the mstatus bitfield.
package kamus_pkg;

  typedef enum logic [11:0] {
    CSR_MSTATUS   = 12'h300,
    CSR_MISA      = 12'h301,
    CSR_MIE       = 12'h304,
    CSR_MTVEC     = 12'h305,
    CSR_MSCRATCH  = 12'h340,
    CSR_MEPC      = 12'h341,
    CSR_MCAUSE    = 12'h342,
    CSR_MIP       = 12'h344,
    CSR_MCYCLE    = 12'hB00,
    CSR_MINSTRET  = 12'hB02,
    CSR_MCYCLEH   = 12'hB80,
    CSR_MINSTRETH = 12'hB82,
    CSR_CYCLE     = 12'hC00,
    CSR_TIME      = 12'hC01,
    CSR_INSTRET   = 12'hC02,
    CSR_CYCLEH    = 12'hC80,
    CSR_TIMEH     = 12'hC81,
    CSR_INSTRETH  = 12'hC82
  } csr_e;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_t;

  typedef enum logic [1:0] {
    CS_IDLE  = 2'd0,
    CS_READ  = 2'd1,
    CS_WRITE = 2'd2
  } csr_state_t;

  typedef struct packed {
    logic mpie;
    logic mie;
  } mstatus_t;

  localparam logic [1:0]  CSR_RO_BITS = 2'b11;
  localparam logic [31:0] MISA_VAL    = 32'h4000_0100;
  localparam logic [31:0] MIE_MASK    = 32'h0000_0888;

  function automatic logic csr_is_ro(input logic [11:0] addr);
    return addr[11:10] == CSR_RO_BITS;
  endfunction

  // MPP is hardwired to M-mode since only M-mode exists.
  function automatic logic [31:0] mstatus_pack(input mstatus_t s);
    return {19'b0, 2'b11, 3'b0, s.mpie, 3'b0, s.mie, 3'b0};
  endfunction

endpackage

// File: rtl/kamus_csr_counter64.sv
// 64-bit counter with increment enable and 32-bit half writes;
// a write to either half suppresses that cycle's increment.
module kamus_csr_counter64 (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        inc_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] value_o
);

  logic [63:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (wr_lo_i || wr_hi_i) begin
      if (wr_lo_i) cnt_d[31:0]  = wdata_i;
      if (wr_hi_i) cnt_d[63:32] = wdata_i;
    end else if (inc_i) begin
      cnt_d = cnt_q + 64'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign value_o = cnt_q;

endmodule

// File: rtl/kamus_csr_unit.sv
// CSR read-modify-write sequencer, counters, trap/mret state.
// Machine-mode CSRs and trap logic gated by KAMUS_MACHINE_MODE_EN.
module kamus_csr_unit
  import kamus_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        csr_req_i,
  input  logic [1:0]  csr_op_i,
  input  logic [11:0] csr_addr_i,
  input  logic [31:0] csr_wdata_i,
  input  logic        csr_wr_suppress_i,
  output logic        csr_ack_o,
  output logic [31:0] csr_rdata_o,
  output logic        csr_illegal_o,
  output logic        busy_o,
  input  logic        retire_i,
  input  logic        trap_i,
  input  logic [31:0] trap_cause_i,
  input  logic [31:0] trap_pc_i,
  input  logic        mret_i,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o
);

  csr_state_t  state_q, state_d;
  logic [31:0] old_q, old_d;
  logic        ill_q, ill_d;
  logic [31:0] rd_val, new_val;
  logic        rd_hit, wr_en, ill_now;
  logic        trap_eff, ack, do_wr;
  logic [63:0] cyc, ins;
  logic        cyc_wr_lo, cyc_wr_hi;
  logic        ins_wr_lo, ins_wr_hi;

  assign wr_en = (csr_op_i == CSR_OP_RW) || !csr_wr_suppress_i;

`ifdef KAMUS_MACHINE_MODE_EN
  mstatus_t    mstatus_q;
  logic [31:0] mtvec_q, mepc_q, mcause_q;
  logic [31:0] mscratch_q, mie_q;
  logic        redir_q;
  logic [31:0] redir_pc_q;

  assign trap_eff = trap_i;
`else
  logic unused_inputs;

  assign trap_eff = 1'b0;
  assign unused_inputs = ^{trap_i, trap_cause_i, trap_pc_i,
                           mret_i, MTVEC_RESET};
`endif

  always_comb begin
    rd_val = '0;
    rd_hit = 1'b1;
    case (csr_addr_i)
      CSR_CYCLE, CSR_TIME:   rd_val = cyc[31:0];
      CSR_CYCLEH, CSR_TIMEH: rd_val = cyc[63:32];
      CSR_INSTRET:           rd_val = ins[31:0];
      CSR_INSTRETH:          rd_val = ins[63:32];
`ifdef KAMUS_MACHINE_MODE_EN
      CSR_MSTATUS:   rd_val = mstatus_pack(mstatus_q);
      CSR_MISA:      rd_val = MISA_VAL;
      CSR_MIE:       rd_val = mie_q;
      CSR_MIP:       rd_val = '0;
      CSR_MTVEC:     rd_val = mtvec_q;
      CSR_MSCRATCH:  rd_val = mscratch_q;
      CSR_MEPC:      rd_val = mepc_q;
      CSR_MCAUSE:    rd_val = mcause_q;
      CSR_MCYCLE:    rd_val = cyc[31:0];
      CSR_MCYCLEH:   rd_val = cyc[63:32];
      CSR_MINSTRET:  rd_val = ins[31:0];
      CSR_MINSTRETH: rd_val = ins[63:32];
`endif
      default:       rd_hit = 1'b0;
    endcase
  end

  assign ill_now = !rd_hit
                || (csr_op_i == CSR_OP_NONE)
                || (csr_is_ro(csr_addr_i) && wr_en);

  always_comb begin
    new_val = old_q;
    unique case (csr_op_i)
      CSR_OP_RW: new_val = csr_wdata_i;
      CSR_OP_RS: new_val = old_q | csr_wdata_i;
      CSR_OP_RC: new_val = old_q & ~csr_wdata_i;
      default:   new_val = old_q;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= CS_IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state; a trap aborts any in-flight op
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CS_IDLE:  if (csr_req_i) state_d = CS_READ;
      CS_READ:  state_d = CS_WRITE;
      CS_WRITE: state_d = CS_IDLE;
      default:  state_d = CS_IDLE;
    endcase
    if (trap_eff) state_d = CS_IDLE;
  end

  // FSM: outputs
  always_comb begin
    ack           = (state_q == CS_WRITE) && !trap_eff && !rst_i;
    csr_ack_o     = ack;
    csr_illegal_o = ack && ill_q;
    csr_rdata_o   = (ack && !ill_q) ? old_q : '0;
    busy_o        = (state_q != CS_IDLE);
  end

  always_comb begin
    old_d = old_q;
    ill_d = ill_q;
    if (state_q == CS_READ) begin
      old_d = rd_val;
      ill_d = ill_now;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      old_q <= '0;
      ill_q <= 1'b0;
    end else begin
      old_q <= old_d;
      ill_q <= ill_d;
    end
  end

  assign do_wr = ack && !ill_q && wr_en;

`ifdef KAMUS_MACHINE_MODE_EN
  assign cyc_wr_lo = do_wr && (csr_addr_i == CSR_MCYCLE);
  assign cyc_wr_hi = do_wr && (csr_addr_i == CSR_MCYCLEH);
  assign ins_wr_lo = do_wr && (csr_addr_i == CSR_MINSTRET);
  assign ins_wr_hi = do_wr && (csr_addr_i == CSR_MINSTRETH);
`else
  assign cyc_wr_lo = 1'b0;
  assign cyc_wr_hi = 1'b0;
  assign ins_wr_lo = 1'b0;
  assign ins_wr_hi = 1'b0;
`endif

  kamus_csr_counter64 u_cycle (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (1'b1),
    .wr_lo_i (cyc_wr_lo),
    .wr_hi_i (cyc_wr_hi),
    .wdata_i (new_val),
    .value_o (cyc)
  );

  kamus_csr_counter64 u_instret (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (retire_i),
    .wr_lo_i (ins_wr_lo),
    .wr_hi_i (ins_wr_hi),
    .wdata_i (new_val),
    .value_o (ins)
  );

`ifdef KAMUS_MACHINE_MODE_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mstatus_q  <= '0;
      mtvec_q    <= {MTVEC_RESET[31:2], 2'b00};
      mepc_q     <= '0;
      mcause_q   <= '0;
      mscratch_q <= '0;
      mie_q      <= '0;
    end else if (trap_i) begin
      mepc_q         <= {trap_pc_i[31:2], 2'b00};
      mcause_q       <= trap_cause_i;
      mstatus_q.mpie <= mstatus_q.mie;
      mstatus_q.mie  <= 1'b0;
    end else begin
      if (mret_i) begin
        mstatus_q.mie  <= mstatus_q.mpie;
        mstatus_q.mpie <= 1'b1;
      end
      if (do_wr) begin
        case (csr_addr_i)
          CSR_MSTATUS: begin
            mstatus_q.mie  <= new_val[3];
            mstatus_q.mpie <= new_val[7];
          end
          CSR_MIE:      mie_q      <= new_val & MIE_MASK;
          CSR_MTVEC:    mtvec_q    <= {new_val[31:2], 2'b00};
          CSR_MSCRATCH: mscratch_q <= new_val;
          CSR_MEPC:     mepc_q     <= {new_val[31:2], 2'b00};
          CSR_MCAUSE:   mcause_q   <= new_val;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      redir_q    <= 1'b0;
      redir_pc_q <= '0;
    end else begin
      redir_q    <= trap_i || mret_i;
      redir_pc_q <= trap_i ? {mtvec_q[31:2], 2'b00}
                  : mret_i ? mepc_q : '0;
    end
  end

  assign redirect_o    = redir_q;
  assign redirect_pc_o = redir_pc_q;
`else
  assign redirect_o    = 1'b0;
  assign redirect_pc_o = '0;
`endif

endmodule

// File: tb/tb_kamus_csr_unit.sv
// Directed scoreboard bench for kamus_csr_unit.
// Machine-mode steps run when KAMUS_MACHINE_MODE_EN is defined.
module tb_kamus_csr_unit;

  localparam logic [1:0] OP_NO = 2'b00;
  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [11:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        sup = 1'b0;
  logic        ack;
  logic [31:0] rdata;
  logic        ill;
  logic        busy;
  logic        retire = 1'b0;
  logic        trap = 1'b0;
  logic [31:0] tcause = '0;
  logic [31:0] tpc = '0;
  logic        mret = 1'b0;
  logic        redir;
  logic [31:0] redir_pc;

  typedef struct packed {
    logic [31:0] rdata;
    logic        ill;
  } exp_t;

  exp_t        sbq[$];
  int          tests = 0;
  int          fails = 0;
  logic [63:0] tb_cyc = '0;
  logic [63:0] exp_ins = '0;
  logic [63:0] tmp;

  kamus_csr_unit dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .csr_req_i         (req),
    .csr_op_i          (op),
    .csr_addr_i        (addr),
    .csr_wdata_i       (wdata),
    .csr_wr_suppress_i (sup),
    .csr_ack_o         (ack),
    .csr_rdata_o       (rdata),
    .csr_illegal_o     (ill),
    .busy_o            (busy),
    .retire_i          (retire),
    .trap_i            (trap),
    .trap_cause_i      (tcause),
    .trap_pc_i         (tpc),
    .mret_i            (mret),
    .redirect_o        (redir),
    .redirect_pc_o     (redir_pc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) tb_cyc <= '0;
    else     tb_cyc <= tb_cyc + 64'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic do_csr(input string tag, input logic [1:0] o,
                        input logic [11:0] a, input logic [31:0] wd,
                        input logic s, input logic [31:0] er,
                        input logic ei, input bit hold);
    exp_t e;
    int   cnt;
    bit   got;
    sbq.push_back('{rdata: er, ill: ei});
    req = 1'b1; op = o; addr = a; wdata = wd; sup = s;
    cnt = 0; got = 1'b0;
    while (!got && cnt < 8) begin
      @(negedge clk);
      if (ack) begin
        got = 1'b1;
        e = sbq.pop_front();
        chk({tag, "_rd"}, rdata, e.rdata);
        chk({tag, "_ill"}, {31'b0, ill}, {31'b0, e.ill});
        chk({tag, "_lat"}, 32'(cnt), 32'd2);
      end else if (cnt == 1) begin
        chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
      end
      @(posedge clk); #1;
      cnt++;
    end
    if (!got) begin
      tests++;
      fails++;
      $error("FAIL %s_timeout: got no ack want ack", tag);
      e = sbq.pop_front();
    end
    if (!hold) req = 1'b0;
  endtask

  task automatic pulse_retire(input int n);
    retire = 1'b1;
    repeat (n) @(posedge clk);
    #1 retire = 1'b0;
    exp_ins = exp_ins + 64'(n);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", {31'b0, ack}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_ill", {31'b0, ill}, 32'd0);
    chk("rst_redir", {31'b0, redir}, 32'd0);
    chk("rst_redir_pc", redir_pc, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // counter reads
    do_csr("cyc", OP_RS, 12'hC00, 32'h0, 1'b1,
           tb_cyc[31:0] + 32'd1, 1'b0, 1'b0);
    do_csr("time", OP_RC, 12'hC01, 32'hFFFF_FFFF, 1'b1,
           tb_cyc[31:0] + 32'd1, 1'b0, 1'b0);
    do_csr("cych", OP_RS, 12'hC80, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0);

    pulse_retire(3);
    do_csr("ins3", OP_RS, 12'hC02, 32'h0, 1'b1,
           exp_ins[31:0], 1'b0, 1'b0);

    // illegal cases
    do_csr("rw_ro", OP_RW, 12'hC02, 32'h1234, 1'b0, 32'h0, 1'b1, 1'b0);
    do_csr("rs_ro", OP_RS, 12'hC02, 32'h1, 1'b0, 32'h0, 1'b1, 1'b0);
    do_csr("op00", OP_NO, 12'hC02, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0);
    do_csr("unmap", OP_RS, 12'h7FF, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0);
    do_csr("ins_same", OP_RS, 12'hC02, 32'h0, 1'b1,
           exp_ins[31:0], 1'b0, 1'b0);

    // back-to-back with req held through ack
    pulse_retire(2);
    do_csr("b2b_a", OP_RS, 12'hC02, 32'h0, 1'b1,
           exp_ins[31:0], 1'b0, 1'b1);
    do_csr("b2b_b", OP_RS, 12'hC82, 32'h0, 1'b1,
           exp_ins[63:32], 1'b0, 1'b0);

`ifdef KAMUS_MACHINE_MODE_EN
    do_csr("ms_rw", OP_RW, 12'h340, 32'hDEAD_BEEF, 1'b0,
           32'h0, 1'b0, 1'b0);
    do_csr("ms_rs", OP_RS, 12'h340, 32'h0000_00F0, 1'b0,
           32'hDEAD_BEEF, 1'b0, 1'b0);
    do_csr("ms_rc", OP_RC, 12'h340, 32'hFFFF_0000, 1'b0,
           32'hDEAD_BEFF, 1'b0, 1'b0);
    do_csr("ms_rd", OP_RS, 12'h340, 32'h0, 1'b1,
           32'h0000_BEFF, 1'b0, 1'b0);

    do_csr("mtvec_w", OP_RW, 12'h305, 32'h0000_0103, 1'b0,
           32'h0, 1'b0, 1'b0);
    do_csr("mtvec_r", OP_RS, 12'h305, 32'h0, 1'b1,
           32'h0000_0100, 1'b0, 1'b0);
    do_csr("mst_w", OP_RW, 12'h300, 32'h0000_0008, 1'b0,
           32'h0000_1800, 1'b0, 1'b0);

    trap = 1'b1; tpc = 32'h0000_0042; tcause = 32'h8000_0007;
    @(posedge clk); #1 trap = 1'b0;
    @(negedge clk);
    chk("trap_redir", {31'b0, redir}, 32'd1);
    chk("trap_pc", redir_pc, 32'h0000_0100);
    @(posedge clk); #1;
    @(negedge clk);
    chk("trap_redir_off", {31'b0, redir}, 32'd0);
    @(posedge clk); #1;
    do_csr("mepc", OP_RS, 12'h341, 32'h0, 1'b1,
           32'h0000_0040, 1'b0, 1'b0);
    do_csr("mcause", OP_RS, 12'h342, 32'h0, 1'b1,
           32'h8000_0007, 1'b0, 1'b0);
    do_csr("mst_trap", OP_RS, 12'h300, 32'h0, 1'b1,
           32'h0000_1880, 1'b0, 1'b0);

    mret = 1'b1;
    @(posedge clk); #1 mret = 1'b0;
    @(negedge clk);
    chk("mret_redir", {31'b0, redir}, 32'd1);
    chk("mret_pc", redir_pc, 32'h0000_0040);
    @(posedge clk); #1;
    do_csr("mst_mret", OP_RS, 12'h300, 32'h0, 1'b1,
           32'h0000_1888, 1'b0, 1'b0);

    // trap aborts an in-flight write
    req = 1'b1; op = OP_RW; addr = 12'h340;
    wdata = 32'h1234_5678; sup = 1'b0;
    @(posedge clk); #1 trap = 1'b1;
    @(negedge clk);
    chk("abort_ack", {31'b0, ack}, 32'd0);
    @(posedge clk); #1 trap = 1'b0; req = 1'b0;
    @(negedge clk);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_ack2", {31'b0, ack}, 32'd0);
    @(posedge clk); #1;
    do_csr("abort_ms", OP_RS, 12'h340, 32'h0, 1'b1,
           32'h0000_BEFF, 1'b0, 1'b0);

    // minstret wrap and write-over-increment
    do_csr("mi_lo", OP_RW, 12'hB02, 32'hFFFF_FFFF, 1'b0,
           exp_ins[31:0], 1'b0, 1'b0);
    do_csr("mi_hi", OP_RW, 12'hB82, 32'h0, 1'b0,
           exp_ins[63:32], 1'b0, 1'b0);
    exp_ins = 64'h0000_0000_FFFF_FFFF;
    pulse_retire(2);
    do_csr("wrap_lo", OP_RS, 12'hC02, 32'h0, 1'b1,
           32'h0000_0001, 1'b0, 1'b0);
    do_csr("wrap_hi", OP_RS, 12'hC82, 32'h0, 1'b1,
           32'h0000_0001, 1'b0, 1'b0);
    retire = 1'b1;
    tmp = exp_ins + 64'd1;
    do_csr("mi_wr_inc", OP_RW, 12'hB02, 32'h0000_0055, 1'b0,
           tmp[31:0], 1'b0, 1'b0);
    retire = 1'b0;
    do_csr("mi_hold", OP_RS, 12'hC02, 32'h0, 1'b1,
           32'h0000_0055, 1'b0, 1'b0);
`else
    do_csr("ms_unmap", OP_RW, 12'h340, 32'hDEAD_BEEF, 1'b0,
           32'h0, 1'b1, 1'b0);
    do_csr("mi_unmap", OP_RW, 12'hB02, 32'h5, 1'b0,
           32'h0, 1'b1, 1'b0);
    trap = 1'b1; mret = 1'b1; tpc = 32'h44; tcause = 32'h2;
    @(posedge clk); #1 trap = 1'b0; mret = 1'b0;
    @(negedge clk);
    chk("trap_ignored", {31'b0, redir}, 32'd0);
    chk("trap_pc_zero", redir_pc, 32'd0);
    @(posedge clk); #1;
`endif

    // reset mid-operation
    req = 1'b1; op = OP_RS; addr = 12'hC02; wdata = '0; sup = 1'b1;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("rstmid_ack", {31'b0, ack}, 32'd0);
    @(posedge clk); #1 rst = 1'b0; req = 1'b0;
    @(negedge clk);
    chk("rstmid_busy", {31'b0, busy}, 32'd0);
    chk("rstmid_ack2", {31'b0, ack}, 32'd0);
    @(posedge clk); #1;
    exp_ins = '0;
    do_csr("rst_ins", OP_RS, 12'hC02, 32'h0, 1'b1,
           exp_ins[31:0], 1'b0, 1'b0);

    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
